// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants and encoder types, used by both the encoder and the control decoder.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011100;

  typedef enum logic [2:0] {
    K_NOP     = 3'd0,
    K_LW      = 3'd1,
    K_SW      = 3'd2,
    K_RTYPE   = 3'd3,
    K_ADDI    = 3'd4,
    K_BEQ     = 3'd5,
    K_J       = 3'd6,
    K_ILLEGAL = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_SLT = 2'd2,
    ALU_MUL = 2'd3
  } alu_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [5:0] funct_of(input alu_e alu);
    case (alu)
      ALU_ADD: return FN_ADD;
      ALU_SUB: return FN_SUB;
      ALU_SLT: return FN_SLT;
      default: return FN_MUL;
    endcase
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Symbolic instruction request bus: one beat per valid/ready handshake.
interface mips_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [1:0]  in_alu;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  modport master (
    output in_valid, in_kind, in_alu, in_rs, in_rt, in_rd, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_alu, in_rs, in_rt, in_rd, in_imm, in_target,
    output in_ready
  );
endinterface

// File: rtl/mips_word_pack.sv
// Combinational packer: symbolic kind plus fields -> 32-bit MIPS word, flagging the illegal kind.
module mips_word_pack
  import mips_isa_pkg::*;
(
  input  kind_e       kind,
  input  alu_e        alu,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    // NOTE: defaults assigned first so every path drives both outputs and no latch is inferred.
    word    = 32'h0;
    illegal = 1'b0;
    case (kind)
      K_LW:      word = {OP_LW,   rs, rt, imm};
      K_SW:      word = {OP_SW,   rs, rt, imm};
      K_ADDI:    word = {OP_ADDI, rs, rt, imm};
      K_BEQ:     word = {OP_BEQ,  rs, rt, imm};
      K_J:       word = {OP_J, target};
      K_RTYPE:   word = {OP_RTYPE, rs, rt, rd, 5'b0, funct_of(alu)};
      K_ILLEGAL: illegal = 1'b1;
      default:   word = 32'h0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Load-session controller: accepts symbolic beats and writes packed words into imem from address 0.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                finish,
  mips_instr_encoder_if.slave req,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     count,
  output logic                err_illegal,
  output logic                err_full
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(IMEM_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] word;
  logic        illegal;
  logic        full;
  logic        accept;

  mips_word_pack u_pack (
    .kind    (kind_e'(req.in_kind)),
    .alu     (alu_e'(req.in_alu)),
    .rs      (req.in_rs),
    .rt      (req.in_rt),
    .rd      (req.in_rd),
    .imm     (req.in_imm),
    .target  (req.in_target),
    .word    (word),
    .illegal (illegal)
  );

  // The word address equals the session count, so one counter serves both.
  assign full         = (count >= DEPTH_C);
  assign req.in_ready = (state_q == S_LOAD) && !full && !finish;
  assign accept       = req.in_valid && req.in_ready;

  assign busy = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_LOAD:  if (finish) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (start) state_d = S_LOAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'h0;
      count       <= '0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= count[ADDR_W-1:0];
        imem_wdata <= word;
      end
      // A beat registered this edge still writes at its old address even if start clears the count.
      if (start) begin
        count       <= '0;
        err_illegal <= 1'b0;
        err_full    <= 1'b0;
      end else begin
        if (accept) count <= count + 1'b1;
        if (accept && illegal) err_illegal <= 1'b1;
        if ((state_q == S_LOAD) && full && req.in_valid) err_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder, run with a 4-word imem to reach the full boundary.
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            finish = 1'b0;
  logic            imem_we;
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_wdata;
  logic            busy;
  logic            done;
  logic [AW:0]     count;
  logic            err_illegal;
  logic            err_full;

  int n_cmp = 0;
  int n_bad = 0;

  mips_instr_encoder_if bus ();

  mips_instr_encoder #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .finish      (finish),
    .req         (bus),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .err_illegal (err_illegal),
    .err_full    (err_full)
  );

  always #5 clk = ~clk;

  // Reference encoding written straight from the instruction formats with arithmetic.
  function automatic logic [31:0] ref_word(input int unsigned kind, alu, rs, rt, rd, imm, target);
    int unsigned fn;
    case (alu)
      0: fn = 32;
      1: fn = 34;
      2: fn = 42;
      default: fn = 28;
    endcase
    case (kind)
      1: return (35 << 26) + (rs << 21) + (rt << 16) + imm;
      2: return (43 << 26) + (rs << 21) + (rt << 16) + imm;
      3: return (rs << 21) + (rt << 16) + (rd << 11) + fn;
      4: return (8 << 26) + (rs << 21) + (rt << 16) + imm;
      5: return (4 << 26) + (rs << 21) + (rt << 16) + imm;
      6: return (2 << 26) + target;
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int unsigned kind, alu, rs, rt, rd, imm, target);
    bus.in_valid  = v;
    bus.in_kind   = 3'(kind);
    bus.in_alu    = 2'(alu);
    bus.in_rs     = 5'(rs);
    bus.in_rt     = 5'(rt);
    bus.in_rd     = 5'(rd);
    bus.in_imm    = 16'(imm);
    bus.in_target = 26'(target);
  endtask

  task automatic idle_bus();
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic close_session();
    idle_bus();
    finish = 1'b1;
    step();
    finish = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_bus();
    #2;
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata, busy, done, count, err_illegal, err_full, bus.in_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h busy=%b done=%b count=%0d ill=%b full=%b rdy=%b, want all 0",
               imem_we, imem_addr, imem_wdata, busy, done, count, err_illegal, err_full, bus.in_ready);
    end
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if ({busy, done, bus.in_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b rdy=%b, want 0 0 0", busy, done, bus.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [AW+32:0] exp_w [3] = '{{1'b1, 2'd0, 32'h8C220004}, {1'b1, 2'd1, 32'h00432022}, {1'b1, 2'd2, 32'h08000010}};
    pulse_start();
    n_cmp++;
    if ({busy, count} !== {1'b1, 3'd0}) begin
      n_bad++;
      $display("FAIL basic_start: got busy=%b count=%0d, want 1 0", busy, count);
    end
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(1'b1, 1, 0, 1, 2, 0, 4, 0);
        1: drive(1'b1, 3, 1, 2, 3, 4, 0, 0);
        default: drive(1'b1, 6, 0, 0, 0, 0, 0, 26'h10);
      endcase
      step();
      n_cmp++;
      if ({imem_we, imem_addr, imem_wdata} !== exp_w[i]) begin
        n_bad++;
        $display("FAIL basic_write%0d: got we=%b addr=%0d data=%h, want %h", i, imem_we, imem_addr, imem_wdata, exp_w[i]);
      end
    end
    idle_bus();
    finish = 1'b1;
    step();
    finish = 1'b0;
    n_cmp++;
    if ({imem_we, busy, done} !== 3'b010) begin
      n_bad++;
      $display("FAIL basic_drain: got we=%b busy=%b done=%b, want 0 1 0", imem_we, busy, done);
    end
    step();
    n_cmp++;
    if ({busy, done, count} !== {1'b0, 1'b1, 3'd3}) begin
      n_bad++;
      $display("FAIL basic_done: got busy=%b done=%b count=%0d, want 0 1 3", busy, done, count);
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_d;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      int unsigned rs = $urandom_range(31), rt = $urandom_range(31), imm = $urandom_range(16'hFFFF);
      drive(1'b1, 4, 0, rs, rt, 0, imm, 0);
      exp_d = ref_word(4, 0, rs, rt, 0, imm, 0);
      #1;
      n_cmp++;
      if (bus.in_ready !== (i < DEPTH)) begin
        n_bad++;
        $display("FAIL fill_ready%0d: got %b, want %b", i, bus.in_ready, (i < DEPTH));
      end
      step();
      n_cmp++;
      if (imem_we !== (i < DEPTH) || (i < DEPTH && {imem_addr, imem_wdata} !== {AW'(i), exp_d})) begin
        n_bad++;
        $display("FAIL fill_write%0d: got we=%b addr=%0d data=%h, want we=%b addr=%0d data=%h",
                 i, imem_we, imem_addr, imem_wdata, (i < DEPTH), i, exp_d);
      end
    end
    idle_bus();
    n_cmp++;
    if ({err_full, count} !== {1'b1, 3'd4}) begin
      n_bad++;
      $display("FAIL fill_status: got err_full=%b count=%0d, want 1 4", err_full, count);
    end
    close_session();
  endtask

  task automatic test_illegal();
    pulse_start();
    drive(1'b1, 7, $urandom_range(3), $urandom_range(31), $urandom_range(31), $urandom_range(31),
          $urandom_range(16'hFFFF), $urandom_range(26'h3FFFFFF));
    step();
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata, err_illegal} !== {1'b1, 2'd0, 32'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL illegal_write: got we=%b addr=%0d data=%h ill=%b, want 1 0 00000000 1",
               imem_we, imem_addr, imem_wdata, err_illegal);
    end
    drive(1'b1, 5, 0, 1, 1, 0, 16'hFFFF, 0);
    step();
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 2'd1, 32'h1021FFFF}) begin
      n_bad++;
      $display("FAIL illegal_beq: got we=%b addr=%0d data=%h, want 1 1 1021ffff", imem_we, imem_addr, imem_wdata);
    end
    close_session();
    n_cmp++;
    if ({done, err_illegal} !== 2'b11) begin
      n_bad++;
      $display("FAIL illegal_sticky: got done=%b ill=%b, want 1 1", done, err_illegal);
    end
    pulse_start();
    n_cmp++;
    if ({busy, err_illegal, count} !== {1'b1, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL illegal_clear: got busy=%b ill=%b count=%0d, want 1 0 0", busy, err_illegal, count);
    end
    close_session();
  endtask

  task automatic test_finish_coincident();
    logic [31:0] exp_d;
    pulse_start();
    drive(1'b1, 2, 0, 5, 6, 0, 16'h1234, 0);
    exp_d = ref_word(2, 0, 5, 6, 0, 16'h1234, 0);
    step();
    drive(1'b1, 1, 0, 7, 8, 0, 16'h55, 0);
    finish = 1'b1;
    #1;
    n_cmp++;
    if ({bus.in_ready, imem_we, imem_addr, imem_wdata} !== {1'b0, 1'b1, 2'd0, exp_d}) begin
      n_bad++;
      $display("FAIL finish_prior: got rdy=%b we=%b addr=%0d data=%h, want 0 1 0 %h",
               bus.in_ready, imem_we, imem_addr, imem_wdata, exp_d);
    end
    step();
    finish = 1'b0;
    idle_bus();
    n_cmp++;
    if ({imem_we, count, busy, done} !== {1'b0, 3'd1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL finish_reject: got we=%b count=%0d busy=%b done=%b, want 0 1 1 0", imem_we, count, busy, done);
    end
    step();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL finish_done: got done=%b, want 1", done);
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata, busy, done, count, err_illegal, err_full, bus.in_ready} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got we=%b addr=%0d data=%h busy=%b done=%b count=%0d rdy=%b, want all 0",
               imem_we, imem_addr, imem_wdata, busy, done, count, bus.in_ready);
    end
    step();
    #2;
    rst = 1'b0;
    step();
    n_cmp++;
    if ({imem_we, busy, count, bus.in_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_idle: got we=%b busy=%b count=%0d rdy=%b, want 0 0 0 0", imem_we, busy, count, bus.in_ready);
    end
    idle_bus();
  endtask

  task automatic test_restart();
    logic [31:0] exp_b, exp_c;
    pulse_start();
    drive(1'b1, 4, 0, 1, 1, 0, 1, 0);
    step();
    drive(1'b1, 3, 2, 9, 10, 11, 0, 0);
    exp_b = ref_word(3, 2, 9, 10, 11, 0, 0);
    step();
    idle_bus();
    start = 1'b1;
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata, count} !== {1'b1, 2'd1, exp_b, 3'd2}) begin
      n_bad++;
      $display("FAIL restart_pending: got we=%b addr=%0d data=%h count=%0d, want 1 1 %h 2",
               imem_we, imem_addr, imem_wdata, count, exp_b);
    end
    step();
    start = 1'b0;
    drive(1'b1, 3, 3, 4, 5, 6, 0, 0);
    exp_c = ref_word(3, 3, 4, 5, 6, 0, 0);
    step();
    idle_bus();
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata, count} !== {1'b1, 2'd0, exp_c, 3'd1}) begin
      n_bad++;
      $display("FAIL restart_first: got we=%b addr=%0d data=%h count=%0d, want 1 0 %h 1",
               imem_we, imem_addr, imem_wdata, count, exp_c);
    end
    close_session();
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      int unsigned m_count = 0;
      logic m_ill = 1'b0, m_full = 1'b0;
      pulse_start();
      for (int c = 0; c < 8; c++) begin
        logic v = ($urandom_range(3) != 0);
        int unsigned k = $urandom_range(7), a = $urandom_range(3);
        int unsigned rs = $urandom_range(31), rt = $urandom_range(31), rd = $urandom_range(31);
        int unsigned imm = $urandom_range(16'hFFFF), tg = $urandom_range(26'h3FFFFFF);
        logic acc = v && (m_count < DEPTH);
        logic [31:0] exp_d = ref_word(k, a, rs, rt, rd, imm, tg);
        drive(v, k, a, rs, rt, rd, imm, tg);
        #1;
        n_cmp++;
        if (bus.in_ready !== (m_count < DEPTH)) begin
          n_bad++;
          $display("FAIL rand_ready s%0d c%0d: got %b, want %b", s, c, bus.in_ready, (m_count < DEPTH));
        end
        step();
        n_cmp++;
        if (imem_we !== acc || (acc && {imem_addr, imem_wdata} !== {AW'(m_count), exp_d})) begin
          n_bad++;
          $display("FAIL rand_write s%0d c%0d: got we=%b addr=%0d data=%h, want we=%b addr=%0d data=%h",
                   s, c, imem_we, imem_addr, imem_wdata, acc, m_count, exp_d);
        end
        if (v && !acc) m_full = 1'b1;
        if (acc && k == 7) m_ill = 1'b1;
        if (acc) m_count++;
        n_cmp++;
        if ({count, err_illegal, err_full} !== {3'(m_count), m_ill, m_full}) begin
          n_bad++;
          $display("FAIL rand_status s%0d c%0d: got count=%0d ill=%b full=%b, want %0d %b %b",
                   s, c, count, err_illegal, err_full, m_count, m_ill, m_full);
        end
      end
      close_session();
      n_cmp++;
      if ({done, count} !== {1'b1, 3'(m_count)}) begin
        n_bad++;
        $display("FAIL rand_done s%0d: got done=%b count=%0d, want 1 %0d", s, done, count, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_illegal();
    test_finish_coincident();
    test_async_reset();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Encoder counterpart of the MIPS control/decode path.
- Accepts symbolic instruction requests (kind, register fields, immediate or target) over a valid/ready handshake.
- Packs each request into a 32-bit MIPS word and writes the words sequentially into instruction memory, starting at address 0.
- Lets the testbench or boot loader fill imem so that the downstream decoder sees exactly the opcodes and functs it recognises.

Parameters:
- IMEM_DEPTH, 64, number of instruction words; load session capacity.
- ADDR_W, 6, imem word-address width; must satisfy 2^ADDR_W >= IMEM_DEPTH.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; opens a load session and clears the address counter.
- finish  in  1  pulse; closes the session.
- in_valid  in  1  request beat valid.
- in_ready  out  1  encoder can accept a beat.
- in_kind  in  3  0=NOP, 1=LW, 2=SW, 3=RTYPE, 4=ADDI, 5=BEQ, 6=J, 7=illegal.
- in_alu  in  2  RTYPE funct select: 0=add, 1=sub, 2=slt, 3=mul.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  I-type immediate.
- in_target  in  26  J-type target.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  high in DONE.
- count  out  ADDR_W+1  words written this session.
- err_illegal  out  1  sticky; an illegal kind was accepted.
- err_full  out  1  sticky; in_valid was asserted while the session was full.

Behaviour:
- Reset (async): state IDLE. All outputs 0, including count, the sticky errors and imem_we.
- States and transitions:
  - IDLE: start -> LOAD.
  - LOAD: finish -> DRAIN.
  - DRAIN: always -> DONE after 1 cycle.
  - DONE: start -> LOAD.
  - start in any state -> LOAD. It clears the address, count and sticky errors.
- in_ready = (state==LOAD) && (accepted count < IDEPTH) && !finish.
- A beat is accepted when in_valid && in_ready.
- Latency is 1 cycle. The cycle after acceptance drives:
  - imem_we = 1 for exactly one cycle;
  - imem_addr = pre-accept address;
  - imem_wdata = encoded word.
  - The address and count then increment.
- Back-to-back beats are accepted every cycle; there is no bubble.
- Encodings:
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - ADDI: {001000, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - J: {000010, target}.
  - RTYPE: {000000, rs, rt, rd, 5'b0, funct}, with funct add=100000, sub=100010, slt=101010, mul=011100.
  - NOP: 32'h0.
- Illegal kind (7): the beat is accepted, 32'h0 is written, and err_illegal is set.
- Full: when count==IMEM_DEPTH, in_ready=0. in_valid held high then sets err_full, and no write occurs. The address never wraps within a session.
- finish together with in_valid in the same cycle: finish has priority, the beat is NOT accepted (in_ready=0), and the state goes to DRAIN.
- DRAIN exists so that the last registered write (from a beat accepted the cycle before finish) completes before done rises.
- start mid-session: a write already registered still issues on the next cycle at its old address. All new beats go from address 0.
- Unused fields for a kind (e.g. rd for LW) are ignored.
- Outputs are registered. in_ready is combinational from state, count and finish.

Decomposition:
- Shared package mips_isa_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J);
  - funct constants (FN_ADD, FN_SUB, FN_SLT, FN_MUL);
  - the in_kind encoding and the state enum.
- The control decoder reuses the same constants.
- One natural sub-module: mips_word_pack, a purely combinational kind/fields -> 32-bit word packer with an illegal flag.
- FSM, counter and output register stay in the top.

Test Plan:
- Reset, then start, then three beats LW(rs=1,rt=2,imm=4), RTYPE sub(rs=2,rt=3,rd=4), J(target=0x10):
  - writes 0x8C220004 @0, 0x00432022 @1, 0x08000010 @2 on consecutive cycles;
  - then finish -> DRAIN -> done=1, count=3.
- Fill test with IMEM_DEPTH=4: valid held for 6 cycles:
  - exactly 4 writes (addr 0..3);
  - in_ready drops after the 4th accept;
  - err_full=1, count=4.
- Illegal kind 7 followed by BEQ(rs=1,rt=1,imm=0xFFFF):
  - writes 0x00000000 @0 and 0x1021FFFF @1;
  - err_illegal=1 sticky until the next start.
- finish in the same cycle as in_valid, one cycle after an accept:
  - the prior beat is written;
  - the coincident beat is not accepted;
  - done rises 2 cycles after finish.
- Async rst asserted mid-session between clock edges:
  - all outputs go to 0 immediately;
  - the state returns to IDLE;
  - in_ready=0 until start.
- Restart: start during LOAD with count=2:
  - the pending write completes at addr 1;
  - the next beat is written at addr 0;
  - count restarts at 1.
